// File: rtl/pool_sparse_encoder_pkg.sv
// Shared constants and state encoding for the pooled-activation sparse encoder.
`timescale 1ns/1ps
package pool_sparse_encoder_pkg;
    localparam int NUM_ACT   = 16;
    localparam int ACT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } enc_state_t;
endpackage

// File: rtl/pool_sparse_encoder_compact16.sv
// Combinational 16-byte compactor: zero/non-zero flags, non-zero bytes packed
// toward byte 0 in ascending index order, and the non-zero count.
`timescale 1ns/1ps
module enc_compact16
    import pool_sparse_encoder_pkg::*;
(
    input  logic [NUM_ACT*ACT_WIDTH-1:0] din,
    output logic [NUM_ACT-1:0]           flag,
    output logic [NUM_ACT*ACT_WIDTH-1:0] cmp_data,
    output logic [4:0]                   nnz
);
    always_comb begin
        flag     = '0;
        cmp_data = '0;
        nnz      = '0;
        // nnz doubles as the running prefix count, i.e. the destination slot
        for (int i = 0; i < NUM_ACT; i++) begin
            flag[i] = |din[i*ACT_WIDTH +: ACT_WIDTH];
            if (flag[i]) begin
                cmp_data[nnz[3:0]*ACT_WIDTH +: ACT_WIDTH] = din[i*ACT_WIDTH +: ACT_WIDTH];
                nnz = nnz + 5'd1;
            end
        end
    end
endmodule

// File: rtl/pool_sparse_encoder.sv
// Sparse activation encoder: per-beat flag words plus non-zero bytes packed
// into dense output words, with a residual buffer carried across beats.
`timescale 1ns/1ps
module pool_sparse_encoder #(
    parameter int NUM_ACT    = pool_sparse_encoder_pkg::NUM_ACT,
    parameter int ACT_WIDTH  = pool_sparse_encoder_pkg::ACT_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int BEAT_WIDTH = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          CFGENC_val,
    output logic                          CFGENC_rdy,
    input  logic [BEAT_WIDTH-1:0]         CFGENC_num_beat,
    input  logic [ADDR_WIDTH-1:0]         CFGENC_data_base,
    input  logic [ADDR_WIDTH-1:0]         CFGENC_flg_base,
    input  logic                          POOLENC_val,
    output logic                          POOLENC_rdy,
    input  logic [NUM_ACT*ACT_WIDTH-1:0]  POOLENC_data,
    output logic                          ENCBF_val,
    input  logic                          ENCBF_rdy,
    output logic [NUM_ACT*ACT_WIDTH-1:0]  ENCBF_data,
    output logic [ADDR_WIDTH-1:0]         ENCBF_addr,
    output logic                          ENCFLG_val,
    input  logic                          ENCFLG_rdy,
    output logic [NUM_ACT-1:0]            ENCFLG_data,
    output logic [ADDR_WIDTH-1:0]         ENCFLG_addr,
    output logic                          ENCCCU_done,
    output logic [ADDR_WIDTH-1:0]         ENCCCU_num_word
);
    import pool_sparse_encoder_pkg::*;

    localparam int BW = NUM_ACT * ACT_WIDTH;
    localparam int RW = (2 * NUM_ACT - 1) * ACT_WIDTH;
    localparam int CW = $clog2(2 * NUM_ACT);

    enc_state_t            state_q, state_d;
    logic [BEAT_WIDTH-1:0] num_beat_q, num_beat_d;
    logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] data_base_q, data_base_d;
    logic [ADDR_WIDTH-1:0] flg_base_q, flg_base_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [RW-1:0]         res_q, res_d;
    logic [CW-1:0]         res_cnt_q, res_cnt_d;
    logic                  bf_val_q, bf_val_d;
    logic [BW-1:0]         bf_data_q, bf_data_d;
    logic [ADDR_WIDTH-1:0] bf_addr_q, bf_addr_d;
    logic                  flg_val_q, flg_val_d;
    logic [NUM_ACT-1:0]    flg_data_q, flg_data_d;
    logic [ADDR_WIDTH-1:0] flg_addr_q, flg_addr_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] num_word_q, num_word_d;

    logic [NUM_ACT-1:0]    beat_flag;
    logic [BW-1:0]         beat_cmp;
    logic [CW-1:0]         beat_nnz;
    logic [CW-1:0]         total;
    logic [RW-1:0]         merged;
    logic                  bf_free, flg_free, beat_acc, last_beat;

    enc_compact16 u_compact (
        .din      (POOLENC_data),
        .flag     (beat_flag),
        .cmp_data (beat_cmp),
        .nnz      (beat_nnz)
    );

    assign bf_free   = !bf_val_q || ENCBF_rdy;
    assign flg_free  = !flg_val_q || ENCFLG_rdy;
    assign beat_acc  = POOLENC_val && POOLENC_rdy;
    assign last_beat = (beat_cnt_q == (num_beat_q - BEAT_WIDTH'(1)));
    // Residual bytes above res_cnt are kept zero, so OR-ing in the new bytes is safe
    assign total     = res_cnt_q + beat_nnz;
    assign merged    = res_q | (RW'(beat_cmp) << (res_cnt_q * ACT_WIDTH));

    always_comb begin
        state_d     = state_q;
        num_beat_d  = num_beat_q;
        beat_cnt_d  = beat_cnt_q;
        data_base_d = data_base_q;
        flg_base_d  = flg_base_q;
        word_cnt_d  = word_cnt_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        bf_val_d    = bf_val_q && !ENCBF_rdy;
        bf_data_d   = bf_data_q;
        bf_addr_d   = bf_addr_q;
        flg_val_d   = flg_val_q && !ENCFLG_rdy;
        flg_data_d  = flg_data_q;
        flg_addr_d  = flg_addr_q;
        done_d      = 1'b0;
        num_word_d  = '0;

        case (state_q)
            IDLE: begin
                if (CFGENC_val) begin
                    num_beat_d  = CFGENC_num_beat;
                    data_base_d = CFGENC_data_base;
                    flg_base_d  = CFGENC_flg_base;
                    beat_cnt_d  = '0;
                    word_cnt_d  = '0;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = (CFGENC_num_beat == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat_acc) begin
                    flg_val_d  = 1'b1;
                    flg_data_d = beat_flag;
                    flg_addr_d = flg_base_q + ADDR_WIDTH'(beat_cnt_q);
                    if (total >= CW'(NUM_ACT)) begin
                        bf_val_d   = 1'b1;
                        bf_data_d  = merged[BW-1:0];
                        bf_addr_d  = data_base_q + word_cnt_q;
                        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                        res_d      = merged >> BW;
                        res_cnt_d  = total - CW'(NUM_ACT);
                    end else begin
                        res_d      = merged;
                        res_cnt_d  = total;
                    end
                    beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (res_cnt_q != '0) begin
                    if (bf_free) begin
                        bf_val_d   = 1'b1;
                        bf_data_d  = res_q[BW-1:0];
                        bf_addr_d  = data_base_q + word_cnt_q;
                        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                        res_d      = '0;
                        res_cnt_d  = '0;
                    end
                end else if (!bf_val_q && !flg_val_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                num_word_d = word_cnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            num_beat_q  <= '0;
            beat_cnt_q  <= '0;
            data_base_q <= '0;
            flg_base_q  <= '0;
            word_cnt_q  <= '0;
            res_q       <= '0;
            res_cnt_q   <= '0;
            bf_val_q    <= 1'b0;
            bf_data_q   <= '0;
            bf_addr_q   <= '0;
            flg_val_q   <= 1'b0;
            flg_data_q  <= '0;
            flg_addr_q  <= '0;
            done_q      <= 1'b0;
            num_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_beat_q  <= num_beat_d;
            beat_cnt_q  <= beat_cnt_d;
            data_base_q <= data_base_d;
            flg_base_q  <= flg_base_d;
            word_cnt_q  <= word_cnt_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            bf_val_q    <= bf_val_d;
            bf_data_q   <= bf_data_d;
            bf_addr_q   <= bf_addr_d;
            flg_val_q   <= flg_val_d;
            flg_data_q  <= flg_data_d;
            flg_addr_q  <= flg_addr_d;
            done_q      <= done_d;
            num_word_q  <= num_word_d;
        end
    end

    assign CFGENC_rdy      = (state_q == IDLE);
    assign POOLENC_rdy     = (state_q == RUN) && bf_free && flg_free;
    assign ENCBF_val       = bf_val_q;
    assign ENCBF_data      = bf_data_q;
    assign ENCBF_addr      = bf_addr_q;
    assign ENCFLG_val      = flg_val_q;
    assign ENCFLG_data     = flg_data_q;
    assign ENCFLG_addr     = flg_addr_q;
    assign ENCCCU_done     = done_q;
    assign ENCCCU_num_word = num_word_q;
endmodule

// File: tb/tb_pool_sparse_encoder.sv
// Self-checking bench for pool_sparse_encoder: table vectors, directed corner
// sequences and randomized groups against a byte-stream reference model.
`timescale 1ns/1ps
module tb_pool_sparse_encoder;
    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         CFGENC_val = 1'b0;
    logic         CFGENC_rdy;
    logic [15:0]  CFGENC_num_beat = '0;
    logic [11:0]  CFGENC_data_base = '0;
    logic [11:0]  CFGENC_flg_base = '0;
    logic         POOLENC_val = 1'b0;
    logic         POOLENC_rdy;
    logic [127:0] POOLENC_data = '0;
    logic         ENCBF_val;
    logic         ENCBF_rdy = 1'b1;
    logic [127:0] ENCBF_data;
    logic [11:0]  ENCBF_addr;
    logic         ENCFLG_val;
    logic         ENCFLG_rdy = 1'b1;
    logic [15:0]  ENCFLG_data;
    logic [11:0]  ENCFLG_addr;
    logic         ENCCCU_done;
    logic [11:0]  ENCCCU_num_word;

    pool_sparse_encoder dut (
        .Clk(Clk), .Reset(Reset),
        .CFGENC_val(CFGENC_val), .CFGENC_rdy(CFGENC_rdy),
        .CFGENC_num_beat(CFGENC_num_beat), .CFGENC_data_base(CFGENC_data_base),
        .CFGENC_flg_base(CFGENC_flg_base),
        .POOLENC_val(POOLENC_val), .POOLENC_rdy(POOLENC_rdy), .POOLENC_data(POOLENC_data),
        .ENCBF_val(ENCBF_val), .ENCBF_rdy(ENCBF_rdy), .ENCBF_data(ENCBF_data), .ENCBF_addr(ENCBF_addr),
        .ENCFLG_val(ENCFLG_val), .ENCFLG_rdy(ENCFLG_rdy), .ENCFLG_data(ENCFLG_data),
        .ENCFLG_addr(ENCFLG_addr),
        .ENCCCU_done(ENCCCU_done), .ENCCCU_num_word(ENCCCU_num_word)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [127:0] beat;
        logic [15:0]  flag;
        logic [127:0] word;
        int           nw;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;
    logic [127:0] got_data[$];
    logic [11:0]  got_daddr[$];
    logic [15:0]  got_flag[$];
    logic [11:0]  got_faddr[$];
    logic [127:0] exp_data[$];
    logic [11:0]  exp_daddr[$];
    logic [15:0]  exp_flag[$];
    logic [11:0]  exp_faddr[$];
    int           exp_nw;
    logic [127:0] cur_beats[$];
    int           done_cnt = 0;
    logic [11:0]  done_nw = '0;
    int           bp_mode = 0;
    int           hold_left = 0;
    int           hold_seen = 0;
    int           flg_in_hold = 0;
    logic [127:0] snap_data = '0;
    logic [11:0]  snap_addr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: advance to the falling edge, drive ready inputs, record the
    // handshakes that will complete on the following rising edge.
    task automatic tick();
        @(negedge Clk);
        if (bp_mode == 2) begin
            if (ENCBF_val && !ENCBF_rdy) begin
                chk("hold_pool_rdy", 128'(POOLENC_rdy), 128'(0));
                chk("hold_bf_data", ENCBF_data, snap_data);
                chk("hold_bf_addr", 128'(ENCBF_addr), 128'(snap_addr));
                hold_seen++;
            end
            if (ENCBF_val && hold_left > 0) begin
                if (ENCBF_rdy) begin
                    snap_data = ENCBF_data;
                    snap_addr = ENCBF_addr;
                end
                ENCBF_rdy = 1'b0;
                hold_left--;
            end else begin
                ENCBF_rdy = 1'b1;
            end
            ENCFLG_rdy = 1'b1;
        end else if (bp_mode == 1) begin
            ENCBF_rdy  = ($urandom_range(0, 3) != 0);
            ENCFLG_rdy = ($urandom_range(0, 3) != 0);
        end else begin
            ENCBF_rdy  = 1'b1;
            ENCFLG_rdy = 1'b1;
        end
        if (!Reset) begin
            if (ENCBF_val && ENCBF_rdy) begin
                got_data.push_back(ENCBF_data);
                got_daddr.push_back(ENCBF_addr);
            end
            if (ENCFLG_val && ENCFLG_rdy) begin
                got_flag.push_back(ENCFLG_data);
                got_faddr.push_back(ENCFLG_addr);
                if (ENCBF_val && !ENCBF_rdy) flg_in_hold++;
            end
            if (ENCCCU_done) begin
                done_cnt++;
                done_nw = ENCCCU_num_word;
            end
        end
    endtask

    task automatic clear_got();
        got_data.delete(); got_daddr.delete(); got_flag.delete(); got_faddr.delete();
    endtask

    task automatic send_config(input logic [15:0] nb, input logic [11:0] db, input logic [11:0] fb);
        for (int t = 0; t < 50 && !CFGENC_rdy; t++) tick();
        chk("cfg_rdy", 128'(CFGENC_rdy), 128'(1));
        CFGENC_num_beat  = nb;
        CFGENC_data_base = db;
        CFGENC_flg_base  = fb;
        CFGENC_val = 1'b1;
        tick();
        CFGENC_val = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] beat);
        logic acc;
        acc = 1'b0;
        POOLENC_data = beat;
        POOLENC_val  = 1'b1;
        for (int t = 0; t < 500 && !acc; t++) begin
            #1;
            if (POOLENC_rdy) acc = 1'b1;
            tick();
        end
        POOLENC_val = 1'b0;
        chk("beat_accept", 128'(acc), 128'(1));
    endtask

    task automatic run_group(input logic [11:0] db, input logic [11:0] fb);
        int start;
        clear_got();
        start = done_cnt;
        send_config(16'(cur_beats.size()), db, fb);
        for (int k = 0; k < cur_beats.size(); k++) send_beat(cur_beats[k]);
        for (int t = 0; t < 1000 && done_cnt == start; t++) tick();
        chk("done_pulse", 128'(done_cnt - start), 128'(1));
    endtask

    // Reference: concatenate all non-zero bytes of the group in arrival order
    // and cut the stream into 16-byte words, zero-padding the last one.
    task automatic build_model(input logic [11:0] db, input logic [11:0] fb);
        logic [7:0]   stream[$];
        logic [127:0] beat, w;
        logic [15:0]  f;
        logic [7:0]   b;
        exp_data.delete(); exp_daddr.delete(); exp_flag.delete(); exp_faddr.delete();
        for (int k = 0; k < cur_beats.size(); k++) begin
            beat = cur_beats[k];
            f = '0;
            for (int i = 0; i < 16; i++) begin
                b = beat[8*i +: 8];
                if (b != 8'd0) begin
                    f[i] = 1'b1;
                    stream.push_back(b);
                end
            end
            exp_flag.push_back(f);
            exp_faddr.push_back(fb + 12'(k));
        end
        for (int s = 0; s < stream.size(); s += 16) begin
            w = '0;
            for (int j = 0; j < 16 && s + j < stream.size(); j++) w[8*j +: 8] = stream[s+j];
            exp_data.push_back(w);
            exp_daddr.push_back(db + 12'(s / 16));
        end
        exp_nw = exp_data.size();
    endtask

    task automatic compare_group(input string tag);
        chk({tag, "_nflag"}, 128'(got_flag.size()), 128'(exp_flag.size()));
        for (int i = 0; i < exp_flag.size() && i < got_flag.size(); i++) begin
            chk({tag, "_flag"}, 128'(got_flag[i]), 128'(exp_flag[i]));
            chk({tag, "_faddr"}, 128'(got_faddr[i]), 128'(exp_faddr[i]));
        end
        chk({tag, "_nword"}, 128'(got_data.size()), 128'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk({tag, "_data"}, got_data[i], exp_data[i]);
            chk({tag, "_daddr"}, 128'(got_daddr[i]), 128'(exp_daddr[i]));
        end
        chk({tag, "_num_word"}, 128'(done_nw), 128'(exp_nw));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cfg_rdy"}, 128'(CFGENC_rdy), 128'(1));
        chk({tag, "_pool_rdy"}, 128'(POOLENC_rdy), 128'(0));
        chk({tag, "_bf_val"}, 128'(ENCBF_val), 128'(0));
        chk({tag, "_bf_data"}, ENCBF_data, 128'(0));
        chk({tag, "_bf_addr"}, 128'(ENCBF_addr), 128'(0));
        chk({tag, "_flg_val"}, 128'(ENCFLG_val), 128'(0));
        chk({tag, "_flg_data"}, 128'(ENCFLG_data), 128'(0));
        chk({tag, "_flg_addr"}, 128'(ENCFLG_addr), 128'(0));
        chk({tag, "_done"}, 128'(ENCCCU_done), 128'(0));
        chk({tag, "_num_word"}, 128'(ENCCCU_num_word), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[6];
        logic [127:0] beat;
        int           nb, dens;

        tbl[0] = '{beat: {16{8'h05}}, flag: 16'hFFFF, word: {16{8'h05}}, nw: 1};
        tbl[1] = '{beat: 128'h0807060504030201, flag: 16'h00FF, word: 128'h0807060504030201, nw: 1};
        tbl[2] = '{beat: 128'h0, flag: 16'h0000, word: 128'h0, nw: 0};
        tbl[3] = '{beat: {8'hAA, 120'h0}, flag: 16'h8000, word: 128'hAA, nw: 1};
        tbl[4] = '{beat: 128'h0F000D000B0009000700050003000100, flag: 16'hAAAA,
                   word: 128'h0F0D0B0907050301, nw: 1};
        tbl[5] = '{beat: {24'h0, 8'h01, 64'h0, 8'hFF, 24'h0}, flag: 16'h1008, word: 128'h01FF, nw: 1};

        tick();
        tick();
        reset_checks("reset");
        Reset = 1'b0;
        tick();

        // Single-beat groups with hand-computed expectations
        for (int i = 0; i < 6; i++) begin
            cur_beats.delete();
            cur_beats.push_back(tbl[i].beat);
            run_group(12'h010 + 12'(i), 12'h020 + 12'(i));
            chk("tbl_nflag", 128'(got_flag.size()), 128'(1));
            if (got_flag.size() > 0) begin
                chk("tbl_flag", 128'(got_flag[0]), 128'(tbl[i].flag));
                chk("tbl_faddr", 128'(got_faddr[0]), 128'(12'h020 + 12'(i)));
            end
            chk("tbl_nword", 128'(got_data.size()), 128'(tbl[i].nw));
            if (tbl[i].nw > 0 && got_data.size() > 0) begin
                chk("tbl_word", got_data[0], tbl[i].word);
                chk("tbl_daddr", 128'(got_daddr[0]), 128'(12'h010 + 12'(i)));
            end
            chk("tbl_num_word", 128'(done_nw), 128'(tbl[i].nw));
        end

        // Two beats, second all zero: flush word carries bytes 1..8
        cur_beats.delete();
        cur_beats.push_back(128'h0807060504030201);
        cur_beats.push_back(128'h0);
        run_group(12'h100, 12'h200);
        build_model(12'h100, 12'h200);
        compare_group("two_beat");
        if (got_data.size() > 0) chk("two_beat_word", got_data[0], 128'h0807060504030201);

        // Three beats of 12 non-zero bytes, crossing word boundaries
        cur_beats.delete();
        for (int k = 0; k < 3; k++) begin
            beat = '0;
            for (int i = 0; i < 16; i++) if ((i % 4) != k) beat[8*i +: 8] = 8'(16 * k + i + 1);
            cur_beats.push_back(beat);
        end
        run_group(12'h040, 12'h080);
        build_model(12'h040, 12'h080);
        compare_group("three_beat");
        chk("three_beat_nw", 128'(done_nw), 128'(3));

        // Same stimulus with the data output stalled for five cycles
        bp_mode = 2; hold_left = 5; hold_seen = 0; flg_in_hold = 0;
        run_group(12'h050, 12'h090);
        build_model(12'h050, 12'h090);
        compare_group("stall");
        chk("stall_cycles", 128'(hold_seen), 128'(5));
        chk("stall_flag_drain", 128'(flg_in_hold > 0), 128'(1));
        bp_mode = 0;

        // Empty group: done two cycles after the config handshake, no traffic
        clear_got();
        send_config(16'd0, 12'h111, 12'h222);
        chk("empty_done_c1", 128'(ENCCCU_done), 128'(0));
        tick();
        chk("empty_done_c2", 128'(ENCCCU_done), 128'(1));
        chk("empty_num_word", 128'(ENCCCU_num_word), 128'(0));
        tick();
        chk("empty_done_c3", 128'(ENCCCU_done), 128'(0));
        chk("empty_traffic", 128'(got_data.size() + got_flag.size()), 128'(0));

        // Address wrap at the top of the address space
        cur_beats.delete();
        for (int k = 0; k < 3; k++) cur_beats.push_back({$urandom, $urandom, $urandom, $urandom} | {16{8'h01}});
        run_group(12'hFFE, 12'hFFF);
        build_model(12'hFFE, 12'hFFF);
        compare_group("wrap");

        // Reset in the middle of a group holding 7 residual bytes
        send_config(16'd4, 12'h0A0, 12'h0B0);
        send_beat(128'h00000000000000000007060504030201);
        chk("pre_rst_flg_val", 128'(ENCFLG_val), 128'(1));
        #1 Reset = 1'b1;
        #1 reset_checks("mid_reset");
        tick();
        Reset = 1'b0;
        tick();
        cur_beats.delete();
        cur_beats.push_back(128'h0C0B0A);
        run_group(12'h300, 12'h400);
        build_model(12'h300, 12'h400);
        compare_group("post_reset");
        if (got_data.size() > 0) chk("post_reset_word", got_data[0], 128'h0C0B0A);

        // Randomized groups with random back-pressure on both outputs
        bp_mode = 1;
        for (int g = 0; g < 25; g++) begin
            nb = $urandom_range(1, 6);
            cur_beats.delete();
            for (int k = 0; k < nb; k++) begin
                dens = $urandom_range(0, 4);
                beat = '0;
                for (int i = 0; i < 16; i++)
                    if ($urandom_range(0, 3) >= dens) beat[8*i +: 8] = 8'($urandom_range(1, 255));
                cur_beats.push_back(beat);
            end
            begin
                logic [11:0] db, fb;
                db = 12'($urandom);
                fb = 12'($urandom);
                run_group(db, fb);
                build_model(db, fb);
                compare_group("random");
            end
        end
        bp_mode = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
